grf_wb_scheduler: RTL and testbench

//  Schedules GRF writes and tracks register hazards from long-latency (LL) units such as the divider and uncached loads.

---
 rtl/grf_sched_pkg.sv | 33 +++
 rtl/grf_wb_skid.sv | 69 ++++++
 rtl/grf_wb_scheduler.sv | 160 ++++++++++++++++
 tb/tb_grf_wb_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_sched_pkg
//  Description : Shared register-address types and skid-buffer state encoding
//                for the GRF write-back scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package grf_sched_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        SKID_EMPTY = 1'b0,
        SKID_HOLD  = 1'b1
    } skid_state_t;

    // A source register stalls D only while busy and not being retired this
    // cycle; a same-cycle retire is bypassed by the GRF to RD1/RD2.
    function automatic logic f_hazard(input logic [NREG-1:0] busy,
                                      input reg_addr_t       r,
                                      input logic            ret,
                                      input reg_addr_t       ret_rd);
        return (r != REG_ZERO) && busy[r] && !(ret && (ret_rd == r));
    endfunction

endpackage

`default_nettype wire

// File: rtl/grf_wb_skid.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_skid
//  Description : One-entry skid buffer holding an LL result that lost the GRF
//                write port to the W stage (EMPTY/HOLD FSM).
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_skid
    import grf_sched_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ll_valid,
    input  reg_addr_t     i_ll_rd,
    input  logic [DW-1:0] i_ll_wd,
    input  logic          i_wb_we,
    output logic          o_ll_ready,
    output logic          o_valid,
    output reg_addr_t     o_rd,
    output logic [DW-1:0] o_wd
);

    skid_state_t   r_state;
    skid_state_t   w_state_nxt;
    reg_addr_t     r_rd;
    logic [DW-1:0] r_wd;
    logic          w_capture;

    assign w_capture = (r_state == SKID_EMPTY) && i_ll_valid && i_wb_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= REG_ZERO;
            r_wd <= '0;
        end else if (w_capture) begin
            r_rd <= i_ll_rd;
            r_wd <= i_ll_wd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SKID_EMPTY: if (w_capture) w_state_nxt = SKID_HOLD;
            SKID_HOLD:  if (!i_wb_we)  w_state_nxt = SKID_EMPTY;
            default:    w_state_nxt = SKID_EMPTY;
        endcase
    end

    // Ready comes straight from the state register, so there is no
    // combinational path from the W-stage write enable to ll_ready.
    assign o_ll_ready = (r_state == SKID_EMPTY);
    assign o_valid    = (r_state == SKID_HOLD);
    assign o_rd       = r_rd;
    assign o_wd       = r_wd;

endmodule

`default_nettype wire

// File: rtl/grf_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_scheduler
//  Description : GRF write-port arbiter and long-latency busy scoreboard with
//                D-stage stall generation. Define LL_SKID_EN to add a one-entry
//                skid buffer for LL results blocked by the W stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_scheduler
    import grf_sched_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int DW          = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic [4:0]                       issue_rd,
    output logic                             issue_ready,
    input  logic [4:0]                       d_rs,
    input  logic [4:0]                       d_rt,
    input  logic [4:0]                       d_rd,
    output logic                             stall,
    input  logic                             wb_we,
    input  logic [4:0]                       wb_a3,
    input  logic [DW-1:0]                    wb_wd,
    input  logic                             ll_valid,
    input  logic [4:0]                       ll_rd,
    input  logic [DW-1:0]                    ll_wd,
    output logic                             ll_ready,
    output logic                             grf_we,
    output logic [4:0]                       grf_a3,
    output logic [DW-1:0]                    grf_wd,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
    output logic                             sb_err
);

    localparam int             C_CW      = $clog2(MAX_PENDING + 1);
    localparam logic [C_CW-1:0] C_MAX_CNT = C_CW'(MAX_PENDING);

    logic [NREG-1:0] r_busy;
    logic [C_CW-1:0] r_cnt;
    logic            r_err;

    logic            w_skid_valid;
    reg_addr_t       w_skid_rd;
    logic [DW-1:0]   w_skid_wd;
    logic            w_ll_ready;
    logic            w_ll_acc;
    logic            w_ll_wr;
    logic            w_ret;
    logic            w_ret_busy;
    logic            w_issue;
    logic            w_same;
    logic            w_inc;
    logic            w_dec;
    logic            w_err_set;
    logic [NREG-1:0] w_busy_nxt;
    logic [C_CW-1:0] w_cnt_nxt;

`ifdef LL_SKID_EN
    grf_wb_skid #(
        .DW (DW)
    ) u_skid (
        .clk        (clk),
        .rst        (reset),
        .i_ll_valid (ll_valid),
        .i_ll_rd    (ll_rd),
        .i_ll_wd    (ll_wd),
        .i_wb_we    (wb_we),
        .o_ll_ready (w_ll_ready),
        .o_valid    (w_skid_valid),
        .o_rd       (w_skid_rd),
        .o_wd       (w_skid_wd)
    );
`else
    assign w_skid_valid = 1'b0;
    assign w_skid_rd    = REG_ZERO;
    assign w_skid_wd    = '0;
    assign w_ll_ready   = !wb_we;
`endif

    assign ll_ready = w_ll_ready;
    assign w_ll_acc = ll_valid && w_ll_ready;

    always_comb begin
        grf_we  = 1'b0;
        grf_a3  = REG_ZERO;
        grf_wd  = '0;
        w_ll_wr = 1'b0;
        if (wb_we) begin
            grf_we = 1'b1;
            grf_a3 = wb_a3;
            grf_wd = wb_wd;
        end else if (w_skid_valid) begin
            grf_we  = 1'b1;
            grf_a3  = w_skid_rd;
            grf_wd  = w_skid_wd;
            w_ll_wr = 1'b1;
        end else if (w_ll_acc) begin
            grf_we  = 1'b1;
            grf_a3  = ll_rd;
            grf_wd  = ll_wd;
            w_ll_wr = 1'b1;
        end
    end

    assign w_ret      = w_ll_wr && (grf_a3 != REG_ZERO);
    assign w_ret_busy = r_busy[grf_a3];

    assign issue_ready = (r_cnt < C_MAX_CNT) && !r_busy[issue_rd];
    assign w_issue     = issue_valid && issue_ready && (issue_rd != REG_ZERO);
    assign w_same      = w_issue && w_ret && (issue_rd == grf_a3);

    // Same-register issue+retire keeps the register busy and the count flat.
    assign w_inc     = w_issue && !w_same;
    assign w_dec     = w_ret && w_ret_busy && (r_cnt != '0) && !w_same;
    assign w_err_set = w_ret && (!w_ret_busy || (r_cnt == '0));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ret) begin
            w_busy_nxt[grf_a3] = 1'b0;
        end
        if (w_issue) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_cnt_nxt = r_cnt;
        if (w_inc && !w_dec) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall = f_hazard(r_busy, d_rs, w_ret, grf_a3) ||
                   f_hazard(r_busy, d_rt, w_ret, grf_a3) ||
                   f_hazard(r_busy, d_rd, w_ret, grf_a3) ||
                   (issue_valid && !issue_ready);

    assign pending_cnt = r_cnt;
    assign sb_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_wb_scheduler
//  Description : Directed scenarios plus randomized traffic against a
//                behavioural scoreboard model for grf_wb_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wb_scheduler;

    localparam int MAXP = 4;
    localparam int DW   = 32;
    localparam int CW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          issue_ready;
    logic [4:0]    d_rs, d_rt, d_rd;
    logic          stall;
    logic          wb_we;
    logic [4:0]    wb_a3;
    logic [DW-1:0] wb_wd;
    logic          ll_valid;
    logic [4:0]    ll_rd;
    logic [DW-1:0] ll_wd;
    logic          ll_ready;
    logic          grf_we;
    logic [4:0]    grf_a3;
    logic [DW-1:0] grf_wd;
    logic [CW-1:0] pending_cnt;
    logic          sb_err;

    int checks = 0;
    int errors = 0;

    // Reference scoreboard state
    bit            m_busy [32];
    int            m_cnt;
    bit            m_err;
    bit            m_held;
    int            m_hrd;
    logic [DW-1:0] m_hwd;

    always #5 clk = ~clk;

    grf_wb_scheduler #(.MAX_PENDING(MAXP), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_rd        (d_rd),
        .stall       (stall),
        .wb_we       (wb_we),
        .wb_a3       (wb_a3),
        .wb_wd       (wb_wd),
        .ll_valid    (ll_valid),
        .ll_rd       (ll_rd),
        .ll_wd       (ll_wd),
        .ll_ready    (ll_ready),
        .grf_we      (grf_we),
        .grf_a3      (grf_a3),
        .grf_wd      (grf_wd),
        .pending_cnt (pending_cnt),
        .sb_err      (sb_err)
    );

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0;
        d_rs = '0; d_rt = '0; d_rd = '0;
        wb_we = 1'b0; wb_a3 = '0; wb_wd = '0;
        ll_valid = 1'b0; ll_rd = '0; ll_wd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", pending_cnt); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", sb_err); end
        checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL rst_grf_we: got %b want 0", grf_we); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL rst_ll_ready: got %b want 1", ll_ready); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %b want 1", issue_ready); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_raw_retire();
        step();
        issue_valid = 1'b1; issue_rd = 5'd8;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t1_issue_ready: got %b want 1", issue_ready); end
        step();
        idle(); d_rs = 5'd8;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t1_raw_stall: got %b want 1", stall); end
        checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL t1_cnt1: got %0d want 1", pending_cnt); end
        ll_valid = 1'b1; ll_rd = 5'd8; ll_wd = 32'h1234;
        #1;
        checks++; if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd8, 32'h1234}) begin errors++; $display("FAIL t1_ll_write: got we=%b a3=%0d wd=%h want we=1 a3=8 wd=1234", grf_we, grf_a3, grf_wd); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL t1_bypass_stall: got %b want 0", stall); end
        step();
        idle();
        #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL t1_cnt0: got %0d want 0", pending_cnt); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL t1_err: got %b want 0", sb_err); end
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            step();
            idle(); issue_valid = 1'b1; issue_rd = 5'(r);
        end
        step();
        idle(); issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        checks++; if (pending_cnt !== 3'd4) begin errors++; $display("FAIL t2_cnt4: got %0d want 4", pending_cnt); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t2_full_ready: got %b want 0", issue_ready); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t2_full_stall: got %b want 1", stall); end
        ll_valid = 1'b1; ll_rd = 5'd2; ll_wd = 32'h22;
        #1;
        checks++; if ({grf_we, grf_a3} !== {1'b1, 5'd2}) begin errors++; $display("FAIL t2_retire2: got we=%b a3=%0d want we=1 a3=2", grf_we, grf_a3); end
        step();
        ll_valid = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after: got %b want 1", issue_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL t2_stall_after: got %b want 0", stall); end
        step();
        idle();
        #1;
        checks++; if (pending_cnt !== 3'd4) begin errors++; $display("FAIL t2_cnt_refill: got %0d want 4", pending_cnt); end
        foreach (m_busy[i]) m_busy[i] = 0;
        for (int k = 0; k < 4; k++) begin
            int rds [4] = '{1, 3, 4, 5};
            if (k > 0) step();
            idle(); ll_valid = 1'b1; ll_rd = 5'(rds[k]);
        end
        step();
        idle();
        #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL t2_drain: got %0d want 0", pending_cnt); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL t2_err: got %b want 0", sb_err); end
    endtask

    task automatic test_port_conflict();
        step();
        idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'hAAAA;
        ll_valid = 1'b1; ll_rd = 5'd9; ll_wd = 32'h9999;
        #1;
        checks++; if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd3, 32'hAAAA}) begin errors++; $display("FAIL t3_wb_wins: got we=%b a3=%0d wd=%h want we=1 a3=3 wd=aaaa", grf_we, grf_a3, grf_wd); end
`ifdef LL_SKID_EN
        checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL t3_skid_accept: got %b want 1", ll_ready); end
        step();
        idle();
        #1;
        checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL t3_hold_ready: got %b want 0", ll_ready); end
        checks++; if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd9, 32'h9999}) begin errors++; $display("FAIL t3_skid_write: got we=%b a3=%0d wd=%h want we=1 a3=9 wd=9999", grf_we, grf_a3, grf_wd); end
        step();
        #1;
        checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_back: got %b want 1", ll_ready); end
`else
        checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL t3_block_ready: got %b want 0", ll_ready); end
        step();
        #1;
        checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL t3_block_ready2: got %b want 0", ll_ready); end
        wb_we = 1'b0;
        #1;
        checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_back: got %b want 1", ll_ready); end
        checks++; if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd9, 32'h9999}) begin errors++; $display("FAIL t3_ll_write: got we=%b a3=%0d wd=%h want we=1 a3=9 wd=9999", grf_we, grf_a3, grf_wd); end
        step();
        idle();
`endif
        #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL t3_cnt: got %0d want 0", pending_cnt); end
    endtask

    task automatic test_same_cycle();
        step();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd6;
        ll_valid = 1'b1; ll_rd = 5'd6; ll_wd = 32'h66;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t4_ready: got %b want 1", issue_ready); end
        step();
        idle(); d_rs = 5'd6;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t4_busy_kept: got stall=%b want 1", stall); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL t4_cnt: got %0d want 0", pending_cnt); end
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL t4_err: got %b want 1", sb_err); end
    endtask

    task automatic test_errors();
        do_reset();
        idle(); ll_valid = 1'b1; ll_rd = 5'd7; ll_wd = 32'h77;
        #1;
        checks++; if ({grf_we, grf_a3} !== {1'b1, 5'd7}) begin errors++; $display("FAIL t5_write7: got we=%b a3=%0d want we=1 a3=7", grf_we, grf_a3); end
        step();
        idle(); issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL t5_err: got %b want 1", sb_err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL t5_r0_stall: got %b want 0", stall); end
        step();
        idle();
        #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL t5_r0_cnt: got %0d want 0", pending_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int r = 10; r <= 12; r++) begin
            idle(); issue_valid = 1'b1; issue_rd = 5'(r);
            step();
        end
        idle();
        wb_we = 1'b1; wb_a3 = 5'd1;
        ll_valid = 1'b1; ll_rd = 5'd10; ll_wd = 32'hA0;
        step();
        ll_valid = 1'b0;
        #1;
        checks++; if (pending_cnt !== 3'd3) begin errors++; $display("FAIL t6_cnt3: got %0d want 3", pending_cnt); end
`ifdef LL_SKID_EN
        checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL t6_hold: got %b want 0", ll_ready); end
`endif
        #2 reset = 1'b1;
        wb_we = 1'b0; d_rs = 5'd11;
        #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL t6_cnt_clr: got %0d want 0", pending_cnt); end
        checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL t6_grf_we: got %b want 0", grf_we); end
        checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL t6_ll_ready: got %b want 1", ll_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL t6_busy_clr: got stall=%b want 0", stall); end
        step();
        reset = 1'b0;
        idle(); ll_valid = 1'b1; ll_rd = 5'd11;
        step();
        idle();
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL t6_late_err: got %b want 1", sb_err); end
    endtask

    task automatic test_random();
        int            busy_list [$];
        logic          e_llr, e_ir, e_we, e_src_ll, e_stall, acc, iss;
        logic [4:0]    e_a3;
        logic [DW-1:0] e_wd;
        int            ret_rd;
        do_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_cnt = 0; m_err = 0; m_held = 0; m_hrd = 0; m_hwd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            busy_list.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
            idle();
            issue_valid = ($urandom_range(0, 9) < 4);
            issue_rd    = 5'($urandom_range(0, 15));
            d_rs = 5'($urandom_range(0, 15));
            d_rt = 5'($urandom_range(0, 15));
            d_rd = 5'($urandom_range(0, 15));
            wb_we = ($urandom_range(0, 9) < 3);
            wb_a3 = 5'($urandom_range(0, 15));
            wb_wd = $urandom;
            ll_valid = ($urandom_range(0, 9) < 4);
            if (busy_list.size() > 0 && $urandom_range(0, 9) < 8)
                ll_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                ll_rd = 5'($urandom_range(0, 15));
            ll_wd = $urandom;
            #1;
`ifdef LL_SKID_EN
            e_llr = !m_held;
`else
            e_llr = !wb_we;
`endif
            e_ir = (m_cnt < MAXP) && !m_busy[issue_rd];
            acc  = ll_valid && e_llr;
            e_we = 1'b1; e_src_ll = 1'b0; e_a3 = wb_a3; e_wd = wb_wd;
            if (wb_we) begin
                e_src_ll = 1'b0;
            end else if (m_held) begin
                e_src_ll = 1'b1; e_a3 = 5'(m_hrd); e_wd = m_hwd;
            end else if (acc) begin
                e_src_ll = 1'b1; e_a3 = ll_rd; e_wd = ll_wd;
            end else begin
                e_we = 1'b0;
            end
            ret_rd  = e_src_ll ? int'(e_a3) : 0;
            e_stall = (issue_valid && !e_ir);
            if (d_rs != 0 && m_busy[d_rs] && int'(d_rs) != ret_rd) e_stall = 1'b1;
            if (d_rt != 0 && m_busy[d_rt] && int'(d_rt) != ret_rd) e_stall = 1'b1;
            if (d_rd != 0 && m_busy[d_rd] && int'(d_rd) != ret_rd) e_stall = 1'b1;

            checks++; if (grf_we !== e_we) begin errors++; $display("FAIL rnd_we cyc%0d: got %b want %b", cyc, grf_we, e_we); end
            if (e_we) begin
                checks++; if ({grf_a3, grf_wd} !== {e_a3, e_wd}) begin errors++; $display("FAIL rnd_port cyc%0d: got a3=%0d wd=%h want a3=%0d wd=%h", cyc, grf_a3, grf_wd, e_a3, e_wd); end
            end
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, stall, e_stall); end
            checks++; if (issue_ready !== e_ir) begin errors++; $display("FAIL rnd_issue_ready cyc%0d: got %b want %b", cyc, issue_ready, e_ir); end
            checks++; if (ll_ready !== e_llr) begin errors++; $display("FAIL rnd_ll_ready cyc%0d: got %b want %b", cyc, ll_ready, e_llr); end
            checks++; if (pending_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc%0d: got %0d want %0d", cyc, pending_cnt, m_cnt); end
            checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_err cyc%0d: got %b want %b", cyc, sb_err, m_err); end

            iss = issue_valid && e_ir && (issue_rd != 0);
            if (ret_rd != 0 && (!m_busy[ret_rd] || m_cnt == 0)) m_err = 1;
            if (iss && ret_rd == int'(issue_rd)) begin
                m_busy[issue_rd] = 1;
            end else begin
                if (ret_rd != 0 && m_busy[ret_rd]) begin
                    m_busy[ret_rd] = 0;
                    if (m_cnt > 0) m_cnt--;
                end
                if (iss) begin
                    m_busy[issue_rd] = 1;
                    m_cnt++;
                end
            end
`ifdef LL_SKID_EN
            if (m_held && !wb_we) m_held = 0;
            else if (acc && wb_we) begin
                m_held = 1; m_hrd = int'(ll_rd); m_hwd = ll_wd;
            end
`endif
            step();
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        test_reset();
        test_raw_retire();
        test_full();
        test_port_conflict();
        test_same_cycle();
        test_errors();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
